if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage 16-bit pipeline; directly upstream of imem.
//  Holds the PC and drives imem's byte address (PC).
//  Captures the returned 16-bit little-endian instruction into the IF/ID pipeline register.
//  Handles stall, flush, branch/jump redirect, halt, and PC wrap over the 64-byte imem.
// PARAMETERS
//  RESET_PC    16'h0000  PC loaded at reset; bit0 must be 0
//  IMEM_BYTES  64        imem size in bytes; power of two; PC wraps modulo this value
// PORTS
//  clk             in   1   single clock; all state updates on posedge clk
//  rst_n           in   1   reset; synchronous, active-low
//  stall           in   1   hazard unit: hold PC and IF/ID
//  flush           in   1   squash the IF/ID contents (insert bubble)
//  redirect_valid  in   1   branch/jump taken in a later stage
//  redirect_pc     in   16  byte target of the redirect
//  halt            in   1   decode saw HALT; freeze fetch
//  imem_pc         out  16  byte address to imem (= PC register, combinational)
//  imem_instr      in   16  instruction from imem; combinational on imem_pc
//  ifid_valid      out  1   IF/ID holds a real instruction
//  ifid_instr      out  16  latched instruction
//  ifid_pc         out  16  address of ifid_instr
//  ifid_pc_plus2   out  16  ifid_pc+2, wrapped modulo IMEM_BYTES (link value)
//  misalign_err    out  1   1-cycle pulse: redirect target had bit0 = 1
//  fetch_count     out  16  fetched-instruction counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - pc = RESET_PC; state = BOOT.
//   - ifid_valid = 0; ifid_instr/ifid_pc/ifid_pc_plus2 = 0.
//   - misalign_err = 0; fetch_count = 0.
//   - Reset mid-stall or mid-halt discards everything.
//  FSM:
//   - BOOT: ifid_valid stays 0 for one cycle while imem settles on RESET_PC, then RUN.
//   - RUN: fetch every cycle, subject to stall/flush/redirect.
//   - HALTED: pc frozen, ifid_valid = 0.
//  Per-cycle priority in RUN and HALTED: rst_n > redirect_valid > halt > stall > normal.
//   - normal: pc <= (pc+2) mod IMEM_BYTES;
//     IF/ID <= {valid=1, imem_instr, pc, (pc+2) mod IMEM_BYTES}.
//     Latency: instruction at PC is visible on ifid_* one cycle after PC is presented.
//   - stall: pc and all IF/ID fields hold their values.
//   - flush: ifid_valid <= 0 regardless of stall; other IF/ID fields don't-care;
//     pc follows stall/normal rules.
//   - redirect: pc <= {redirect_pc[15:1],1'b0} mod IMEM_BYTES; ifid_valid <= 0;
//     overrides stall and halt. From HALTED, go to RUN.
//     If redirect_pc[0]=1, misalign_err=1 in the following cycle only.
//   - halt (no redirect): go to HALTED next cycle; ifid_valid <= 0.
//     Only redirect or reset leaves HALTED.
//  Boundaries:
//   - pc = IMEM_BYTES-2 advances to 0.
//   - redirect_pc >= IMEM_BYTES is masked to its low log2(IMEM_BYTES) bits.
//   - Inputs in BOOT are ignored, except rst_n.
//   - imem_pc upper bits above log2(IMEM_BYTES) are always 0.
// CONFIGURATION
//  IF_PERF_CNT_EN defined:
//   - fetch_count += 1 (wraps at 16'hFFFF) on every posedge where ifid_valid is written 1.
//  IF_PERF_CNT_EN undefined:
//   - counter logic is absent; fetch_count is tied to 16'h0000.
// TESTING
//  1. rst_n low 2 cycles, then high:
//     imem_pc=0000, ifid_valid=0 for 1 cycle, then ifid_pc=0000,0002,0004 on consecutive cycles.
//  2. Run to pc=003E, no events:
//     next imem_pc=0000; ifid_pc=003E with ifid_pc_plus2=0000.
//  3. stall=1 for 3 cycles at ifid_pc=0006:
//     ifid_* and imem_pc unchanged; on release ifid_pc=0008.
//  4. redirect_valid=1, redirect_pc=0015, with stall=1:
//     imem_pc=0014; ifid_valid=0 next cycle; misalign_err=1 one cycle;
//     following cycle ifid_pc=0014.
//  5. halt=1 one cycle:
//     ifid_valid=0 and imem_pc frozen for 10 cycles.
//     redirect_pc=0020 -> ifid_pc=0020, ifid_valid=1 two cycles later.
//  6. IF_PERF_CNT_EN defined, 5 normal fetches plus 1 flush:
//     fetch_count=5; undefined: fetch_count=0 throughout.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Purpose : instruction-fetch stage; owns the PC, drives imem, latches the IF/ID register.
// Latency : instruction at imem_pc appears on ifid_* one cycle after the PC is presented.
// Backpr. : stall holds PC and IF/ID; redirect overrides stall/halt; halt freezes fetch.
//
// Ports
//   clk, rst_n          single clock, synchronous active-low reset
//   stall, flush        hazard-unit hold / bubble insertion into IF/ID
//   redirect_valid/_pc  taken branch or jump from a later stage (byte target)
//   halt                decode saw HALT; fetch freezes until redirect or reset
//   imem_pc/imem_instr  byte address to imem / combinational instruction back
//   ifid_*              IF/ID pipeline register (valid, instr, pc, pc+2 link)
//   misalign_err        one-cycle pulse after a redirect to an odd address
//   fetch_count         fetched-instruction counter
//
// Optional feature: define IF_PERF_CNT_EN to build the fetch counter;
// otherwise fetch_count is tied to zero.

module if_fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          IMEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus2,
    output logic        misalign_err,
    output logic [15:0] fetch_count
);

    // IMEM_BYTES is a power of two, so "mod IMEM_BYTES" is a mask. Bit 0 is
    // also cleared wherever a PC is formed so instructions stay halfword aligned.
    localparam logic [15:0] ADDR_MASK  = 16'(IMEM_BYTES - 1);
    localparam logic [15:0] ALIGN_MASK = ADDR_MASK & 16'hFFFE;
    localparam logic [15:0] PC_INIT    = RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] pc_inc;
    logic [15:0] redir_tgt;
    logic        valid_nxt;
    logic [15:0] instr_nxt;
    logic [15:0] ifid_pc_nxt;
    logic [15:0] ifid_plus2_nxt;
    logic        misalign_nxt;

    assign pc_inc    = (pc + 16'd2) & ADDR_MASK;
    assign redir_tgt = redirect_pc & ALIGN_MASK;

    // pc only ever holds masked values, so the upper address bits are zero.
    assign imem_pc = pc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-value logic.
    // Priority in RUN/HALTED: redirect > halt > stall > normal; flush only
    // kills the valid bit and never affects the PC.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        valid_nxt      = ifid_valid;
        instr_nxt      = ifid_instr;
        ifid_pc_nxt    = ifid_pc;
        ifid_plus2_nxt = ifid_pc_plus2;
        misalign_nxt   = 1'b0;

        unique case (state)
            ST_BOOT: begin
                // One dead cycle while imem settles on the reset PC; every
                // input other than rst_n is ignored here.
                valid_nxt = 1'b0;
                state_nxt = ST_RUN;
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    pc_nxt       = redir_tgt;
                    valid_nxt    = 1'b0;
                    misalign_nxt = redirect_pc[0];
                end else if (halt) begin
                    // PC holds so imem_pc stays frozen on the next fetch address.
                    state_nxt = ST_HALTED;
                    valid_nxt = 1'b0;
                end else if (stall) begin
                    if (flush) begin
                        valid_nxt = 1'b0;
                    end
                end else begin
                    pc_nxt         = pc_inc;
                    valid_nxt      = !flush;
                    instr_nxt      = imem_instr;
                    ifid_pc_nxt    = pc;
                    ifid_plus2_nxt = pc_inc;
                end
            end

            ST_HALTED: begin
                valid_nxt = 1'b0;
                if (redirect_valid) begin
                    pc_nxt       = redir_tgt;
                    misalign_nxt = redirect_pc[0];
                    state_nxt    = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_BOOT;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC and IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc            <= PC_INIT;
            ifid_valid    <= 1'b0;
            ifid_instr    <= 16'h0000;
            ifid_pc       <= 16'h0000;
            ifid_pc_plus2 <= 16'h0000;
            misalign_err  <= 1'b0;
        end else begin
            pc            <= pc_nxt;
            ifid_valid    <= valid_nxt;
            ifid_instr    <= instr_nxt;
            ifid_pc       <= ifid_pc_nxt;
            ifid_pc_plus2 <= ifid_plus2_nxt;
            misalign_err  <= misalign_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Fetch counter: increments exactly when a real instruction is written
    // into IF/ID (normal advance without flush).
    // ------------------------------------------------------------------
`ifdef IF_PERF_CNT_EN
    logic        fetch_wr;
    logic [15:0] fetch_cnt_q;

    assign fetch_wr = (state == ST_RUN) && !redirect_valid && !halt && !stall && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= 16'h0000;
        end else if (fetch_wr) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
`else
    assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, sequential fetch, wrap, stall,
// flush, misaligned redirect, masked redirect, halt, reset while halted.
`timescale 1ns/1ps

module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus2;
    logic        misalign_err;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // imem model: instruction word encodes its own address.
    assign imem_instr = {8'hC3, imem_pc[7:0]};

    if_fetch_stage #(
        .RESET_PC  (16'h0000),
        .IMEM_BYTES(64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .imem_pc       (imem_pc),
        .imem_instr    (imem_instr),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%04h exp=%04h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cnt_exp(input int n);
`ifdef IF_PERF_CNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;

        // Reset state
        tick(); tick();
        chk("rst_imem_pc",  imem_pc, 16'h0000);
        chk("rst_valid",    {15'd0, ifid_valid}, 16'h0000);
        chk("rst_ifid_pc",  ifid_pc, 16'h0000);
        chk("rst_instr",    ifid_instr, 16'h0000);
        chk("rst_plus2",    ifid_pc_plus2, 16'h0000);
        chk("rst_misalign", {15'd0, misalign_err}, 16'h0000);
        chk("rst_count",    fetch_count, 16'h0000);

        // Boot cycle, then sequential fetch
        rst_n = 1'b1;
        tick();
        chk("boot_valid",   {15'd0, ifid_valid}, 16'h0000);
        chk("boot_imem_pc", imem_pc, 16'h0000);
        tick();
        chk("f0_valid", {15'd0, ifid_valid}, 16'h0001);
        chk("f0_pc",    ifid_pc, 16'h0000);
        chk("f0_instr", ifid_instr, 16'hC300);
        chk("f0_plus2", ifid_pc_plus2, 16'h0002);
        chk("f0_imem",  imem_pc, 16'h0002);
        tick();
        chk("f1_pc", ifid_pc, 16'h0002);
        tick();
        chk("f2_pc",   ifid_pc, 16'h0004);
        chk("f2_imem", imem_pc, 16'h0006);
        tick();
        chk("f3_pc", ifid_pc, 16'h0006);

        // Stall three cycles at ifid_pc=0006
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",    ifid_pc, 16'h0006);
            chk("stall_instr", ifid_instr, 16'hC306);
            chk("stall_valid", {15'd0, ifid_valid}, 16'h0001);
            chk("stall_imem",  imem_pc, 16'h0008);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc",   ifid_pc, 16'h0008);
        chk("unstall_imem", imem_pc, 16'h000A);

        // Flush: bubble inserted, PC still advances, no count
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {15'd0, ifid_valid}, 16'h0000);
        chk("flush_imem",  imem_pc, 16'h000C);
        chk("flush_count", fetch_count, cnt_exp(5));

        // Misaligned redirect under stall
        redirect_valid = 1'b1; redirect_pc = 16'h0015; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        chk("redir_imem",     imem_pc, 16'h0014);
        chk("redir_valid",    {15'd0, ifid_valid}, 16'h0000);
        chk("redir_misalign", {15'd0, misalign_err}, 16'h0001);
        tick();
        chk("redir_pc",        ifid_pc, 16'h0014);
        chk("redir_valid2",    {15'd0, ifid_valid}, 16'h0001);
        chk("redir_misalign2", {15'd0, misalign_err}, 16'h0000);
        chk("redir_imem2",     imem_pc, 16'h0016);

        // Wrap at end of imem
        redirect_valid = 1'b1; redirect_pc = 16'h003C;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_misalign", {15'd0, misalign_err}, 16'h0000);
        tick();
        chk("wrap_pc3c",  ifid_pc, 16'h003C);
        chk("wrap_imem3e", imem_pc, 16'h003E);
        tick();
        chk("wrap_pc3e",    ifid_pc, 16'h003E);
        chk("wrap_plus2",   ifid_pc_plus2, 16'h0000);
        chk("wrap_instr",   ifid_instr, 16'hC33E);
        chk("wrap_imem0",   imem_pc, 16'h0000);
        tick();
        chk("wrap_pc0",   ifid_pc, 16'h0000);
        chk("wrap_count", fetch_count, cnt_exp(9));

        // Out-of-range redirect is masked; redirect overrides halt
        redirect_valid = 1'b1; redirect_pc = 16'h1236; halt = 1'b1;
        tick();
        redirect_valid = 1'b0; halt = 1'b0;
        chk("mask_imem",  imem_pc, 16'h0036);
        chk("mask_valid", {15'd0, ifid_valid}, 16'h0000);
        tick();
        chk("mask_pc",    ifid_pc, 16'h0036);
        chk("mask_valid2", {15'd0, ifid_valid}, 16'h0001);

        // Halt: frozen until redirect
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("halt_valid", {15'd0, ifid_valid}, 16'h0000);
            chk("halt_imem",  imem_pc, 16'h0038);
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        chk("unhalt_imem",  imem_pc, 16'h0020);
        chk("unhalt_valid", {15'd0, ifid_valid}, 16'h0000);
        tick();
        chk("unhalt_pc",     ifid_pc, 16'h0020);
        chk("unhalt_valid2", {15'd0, ifid_valid}, 16'h0001);
        chk("unhalt_count",  fetch_count, cnt_exp(11));

        // Reset while halted discards everything
        halt = 1'b1;
        tick();
        halt = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rst2_imem",  imem_pc, 16'h0000);
        chk("rst2_pc",    ifid_pc, 16'h0000);
        chk("rst2_valid", {15'd0, ifid_valid}, 16'h0000);
        chk("rst2_count", fetch_count, 16'h0000);

        // Inputs during BOOT are ignored
        rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0011;
        tick();
        redirect_valid = 1'b0;
        chk("boot_ign_imem",     imem_pc, 16'h0000);
        chk("boot_ign_misalign", {15'd0, misalign_err}, 16'h0000);
        tick();
        chk("boot_ign_pc",    ifid_pc, 16'h0000);
        chk("boot_ign_valid", {15'd0, ifid_valid}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
